sb_corner_param: RTL and testbench
==================================

// Module: sb_corner_param
// PURPOSE
//  Parametrised corner switch block: CHAN_W-track top (Y) and right (X) channels plus grid pins.
//  Every output track has one MUX_SIZE:1 routing mux. The config chain fills a shadow shift register.
//  A full frame is committed atomically to the active select registers.
//  Sits on the prog_clk configuration chain (ccff_head -> ccff_tail) like all routing blocks.
// PARAMETERS
//  CHAN_W       20  tracks per channel side
//  NUM_TOP_PINS 1   top grid pins feeding top muxes
//  NUM_RGT_PINS 6   right grid pins feeding right muxes
//  MUX_SIZE     4   inputs per mux (1 channel track + MUX_SIZE-1 grid pins), >=2
//  SEL_W        $clog2(MUX_SIZE)  select bits per mux (localparam)
//  CFG_BITS     2*CHAN_W*SEL_W    frame length excl. parity (localparam)
// PORTS
//  prog_clk        in  1             configuration clock
//  prog_rst_n      in  1             async active-low reset
//  ccff_en         in  1             shift enable; chain shifts one bit per prog_clk when high
//  ccff_head       in  1             serial config in
//  ccff_tail       out 1             serial config out (MSB of shadow)
//  chany_top_in    in  CHAN_W        top channel inputs
//  chanx_right_in  in  CHAN_W        right channel inputs
//  top_pins        in  NUM_TOP_PINS  top grid pins
//  right_pins      in  NUM_RGT_PINS  right grid pins
//  chany_top_out   out CHAN_W        top channel outputs
//  chanx_right_out out CHAN_W        right channel outputs
//  cfg_valid       out 1             a frame has been committed since reset
//  cfg_err         out 1             sticky parity error (CFG_PARITY_EN only, else 0)
// BEHAVIOUR
//  - Reset: shadow, active selects, bit counter 0; cfg_valid=0, cfg_err=0, ccff_tail=0.
//  - Shift, when ccff_en=1: sr <= {sr[N-2:0], ccff_head}; ccff_tail=sr[N-1]; N=CFG_BITS (+1 with parity).
//  - Field map: mux m at sr[OFF+m*SEL_W +: SEL_W], MSB first. m=0..CHAN_W-1 top; m=CHAN_W..2*CHAN_W-1 right.
//    OFF=0, or 1 with parity.
//  - Counter cnt 0..N-1 increments per shift. A shift at cnt==N-1 wraps cnt to 0 and raises commit.
//  - Commit: on the next prog_clk edge active<=shadow fields and cfg_valid<=1. Outputs change 1 cycle after the last bit.
//  - ccff_en=0: counter and shadow hold. A partial frame never affects outputs.
//  - A shift coincident with commit is legal: the new frame starts, and the commit uses the completed frame.
//  - Reset mid-frame: everything returns to reset values; the partial frame is discarded.
//  - Top mux i (combinational from active sel s):
//    s=0 -> chanx_right_in[(i+1)%CHAN_W]; s=j in 1..MUX_SIZE-1 -> top_pins[(i+j-1)%NUM_TOP_PINS].
//  - Right mux i:
//    s=0 -> chany_top_in[(i+CHAN_W-1)%CHAN_W]; s=j -> right_pins[(i+j-1)%NUM_RGT_PINS].
//  - s>=MUX_SIZE (non-power-of-2 sizes) drives 0.
// CONFIGURATION
//  - Macro SB_CFG_PARITY_EN.
//  - Defined: the frame carries 1 extra bit, sr[0], the last bit shifted.
//    Commit only if the XOR over all N bits is 0 (even parity).
//    On mismatch: active selects and cfg_valid hold, cfg_err<=1.
//    cfg_err clears on reset or on the next good commit.
//  - Undefined: N=CFG_BITS, every frame commits, cfg_err tied 0.
// STRUCTURE
//  - Package sb_cfg_pkg: sel_w(), cfg_bits() functions and an enum of mux side (SIDE_TOP, SIDE_RIGHT).
//  - One sub-module sb_route_mux (MUX_SIZE, SEL_W): combinational in/sel->out.
//    Instantiated 2*CHAN_W times via generate.
//  - Chain/counter/commit logic lives in the top module.
// TESTING (CHAN_W=4, NUM_TOP_PINS=2, NUM_RGT_PINS=2, MUX_SIZE=4; N=16, or 17 with parity)
//  1. Reset then no shifting, chanx_right_in=4'b0010 -> chany_top_out=4'b0001, cfg_valid=0.
//  2. Shift 16 bits selecting s=1 for all muxes, top_pins=2'b01
//     -> cfg_valid rises 1 cycle after bit 16; chany_top_out[0]=1, [1]=0 (pin(i)%2).
//  3. Shift 10 of 16 bits, hold ccff_en=0 for 5 cycles -> outputs unchanged.
//     Resume the last 6 bits -> commit follows.
//  4. Chain passthrough: 32 shifts of pattern 0xA5A5_5A5A
//     -> ccff_tail reproduces the first 16 bits delayed by 16 cycles; 2 commits occur.
//  5. Assert prog_rst_n low at bit 8 -> all selects 0, cfg_valid=0.
//     The next full 16-bit frame commits normally.
//  6. (SB_CFG_PARITY_EN) Frame with a wrong parity bit -> cfg_err=1, outputs unchanged.
//     The next frame with good parity -> cfg_err=0 and a new config is active.

Source files
------------

// File: rtl/sb_cfg_pkg.sv
// Shared types and sizing helpers for the corner switch block configuration.
// Parity framing is selected by the SB_CFG_PARITY_EN macro in the top module.
package sb_cfg_pkg;

    typedef enum logic {
        SIDE_TOP   = 1'b0,
        SIDE_RIGHT = 1'b1
    } side_e;

    function automatic int sel_w(input int mux_size);
        return $clog2(mux_size);
    endfunction

    function automatic int cfg_bits(input int chan_w, input int mux_size);
        return 2 * chan_w * sel_w(mux_size);
    endfunction

endpackage

// File: rtl/sb_route_mux.sv
// One routing mux: combinational MUX_SIZE:1 select; selects past MUX_SIZE-1 drive 0.
module sb_route_mux #(
    parameter int MUX_SIZE = 4,
    parameter int SEL_W    = 2
) (
    input  logic [MUX_SIZE-1:0] in_i,
    input  logic [SEL_W-1:0]    sel_i,
    output logic                out_o
);

    always_comb begin
        out_o = 1'b0;
        for (int j = 0; j < MUX_SIZE; j++) begin
            if (sel_i == SEL_W'(j)) out_o = in_i[j];
        end
    end

endmodule

// File: rtl/sb_corner_param.sv
// Corner switch block: serial config chain with atomic frame commit driving 2*CHAN_W muxes.
// Define SB_CFG_PARITY_EN to append an even-parity bit to each frame and gate commits on it.
module sb_corner_param
    import sb_cfg_pkg::*;
#(
    parameter int CHAN_W       = 20,
    parameter int NUM_TOP_PINS = 1,
    parameter int NUM_RGT_PINS = 6,
    parameter int MUX_SIZE     = 4
) (
    input  logic                    prog_clk,
    input  logic                    prog_rst_n,
    input  logic                    ccff_en,
    input  logic                    ccff_head,
    output logic                    ccff_tail,
    input  logic [CHAN_W-1:0]       chany_top_in,
    input  logic [CHAN_W-1:0]       chanx_right_in,
    input  logic [NUM_TOP_PINS-1:0] top_pins,
    input  logic [NUM_RGT_PINS-1:0] right_pins,
    output logic [CHAN_W-1:0]       chany_top_out,
    output logic [CHAN_W-1:0]       chanx_right_out,
    output logic                    cfg_valid,
    output logic                    cfg_err
);

    localparam int SEL_W    = sel_w(MUX_SIZE);
    localparam int CFG_BITS = cfg_bits(CHAN_W, MUX_SIZE);
`ifdef SB_CFG_PARITY_EN
    localparam int PAR      = 1;
`else
    localparam int PAR      = 0;
`endif
    localparam int N        = CFG_BITS + PAR;
    localparam int CNT_W    = $clog2(N);

    logic [N-1:0]        sr_q, sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                commit_q, commit_d;
    logic [CFG_BITS-1:0] act_q, act_d;
    logic                valid_q, valid_d;
    logic                frame_ok;

`ifdef SB_CFG_PARITY_EN
    logic err_q, err_d;

    // Even parity over the whole frame, parity bit included.
    assign frame_ok = ~(^sr_q);

    always_comb begin
        err_d = err_q;
        if (commit_q) err_d = ~frame_ok;
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) err_q <= 1'b0;
        else             err_q <= err_d;
    end

    assign cfg_err = err_q;
`else
    assign frame_ok = 1'b1;
    assign cfg_err  = 1'b0;
`endif

    // commit_q is set by the edge that shifts the last bit, so the commit edge still sees
    // the completed frame in sr_q even if the next frame starts shifting on that same edge.
    always_comb begin
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        commit_d = 1'b0;
        if (ccff_en) begin
            sr_d = {sr_q[N-2:0], ccff_head};
            if (cnt_q == CNT_W'(N - 1)) begin
                cnt_d    = '0;
                commit_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        act_d   = act_q;
        valid_d = valid_q;
        if (commit_q && frame_ok) begin
            act_d   = sr_q[PAR +: CFG_BITS];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            sr_q     <= '0;
            cnt_q    <= '0;
            commit_q <= 1'b0;
            act_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            commit_q <= commit_d;
            act_q    <= act_d;
            valid_q  <= valid_d;
        end
    end

    assign ccff_tail = sr_q[N-1];
    assign cfg_valid = valid_q;

    for (genvar m = 0; m < 2 * CHAN_W; m++) begin : g_mux
        localparam side_e SIDE = (m < CHAN_W) ? SIDE_TOP : SIDE_RIGHT;
        localparam int    I    = (m < CHAN_W) ? m : m - CHAN_W;
        logic [MUX_SIZE-1:0] mux_in;
        logic                mux_out;

        if (SIDE == SIDE_TOP) begin : g_top
            assign mux_in[0] = chanx_right_in[(I + 1) % CHAN_W];
            for (genvar j = 1; j < MUX_SIZE; j++) begin : g_pin
                assign mux_in[j] = top_pins[(I + j - 1) % NUM_TOP_PINS];
            end
            assign chany_top_out[I] = mux_out;
        end else begin : g_right
            assign mux_in[0] = chany_top_in[(I + CHAN_W - 1) % CHAN_W];
            for (genvar j = 1; j < MUX_SIZE; j++) begin : g_pin
                assign mux_in[j] = right_pins[(I + j - 1) % NUM_RGT_PINS];
            end
            assign chanx_right_out[I] = mux_out;
        end

        sb_route_mux #(
            .MUX_SIZE(MUX_SIZE),
            .SEL_W   (SEL_W)
        ) u_mux (
            .in_i (mux_in),
            .sel_i(act_q[m*SEL_W +: SEL_W]),
            .out_o(mux_out)
        );
    end

endmodule

// File: tb/tb_sb_corner_param.sv
// Scoreboard bench for sb_corner_param (CHAN_W=4, 2 top pins, 2 right pins, 4:1 muxes).
`timescale 1ns/1ps
module tb_sb_corner_param;

`ifdef SB_CFG_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB = 16 + PB;

    logic       prog_clk = 1'b0;
    logic       prog_rst_n = 1'b0;
    logic       ccff_en = 1'b0;
    logic       ccff_head = 1'b0;
    logic       ccff_tail;
    logic [3:0] chany_top_in = '0;
    logic [3:0] chanx_right_in = '0;
    logic [1:0] top_pins = '0;
    logic [1:0] right_pins = '0;
    logic [3:0] chany_top_out;
    logic [3:0] chanx_right_out;
    logic       cfg_valid;
    logic       cfg_err;

    sb_corner_param #(
        .CHAN_W      (4),
        .NUM_TOP_PINS(2),
        .NUM_RGT_PINS(2),
        .MUX_SIZE    (4)
    ) dut (
        .prog_clk       (prog_clk),
        .prog_rst_n     (prog_rst_n),
        .ccff_en        (ccff_en),
        .ccff_head      (ccff_head),
        .ccff_tail      (ccff_tail),
        .chany_top_in   (chany_top_in),
        .chanx_right_in (chanx_right_in),
        .top_pins       (top_pins),
        .right_pins     (right_pins),
        .chany_top_out  (chany_top_out),
        .chanx_right_out(chanx_right_out),
        .cfg_valid      (cfg_valid),
        .cfg_err        (cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    int cyc = 0;
    always @(posedge prog_clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         chk_out;
        bit         chk_tail;
        logic [3:0] top;
        logic [3:0] rgt;
        logic       vld;
        logic       err;
        logic       tail;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    vectors = 0;
    int    miscompares = 0;

    // Reference state: committed selects (mux m at bits 2m+1:2m), valid and error flags.
    logic [15:0] msel = '0;
    logic        mvalid = 1'b0;
    logic        merr = 1'b0;

    function automatic logic [3:0] m_top();
        logic [3:0] r;
        int s;
        for (int i = 0; i < 4; i++) begin
            s = int'(msel[2*i +: 2]);
            r[i] = (s == 0) ? chanx_right_in[(i + 1) % 4] : top_pins[(i + s - 1) % 2];
        end
        return r;
    endfunction

    function automatic logic [3:0] m_rgt();
        logic [3:0] r;
        int s;
        for (int i = 0; i < 4; i++) begin
            s = int'(msel[2*(i + 4) +: 2]);
            r[i] = (s == 0) ? chany_top_in[(i + 3) % 4] : right_pins[(i + s - 1) % 2];
        end
        return r;
    endfunction

    task automatic push_exp(input string nm, input int c, input bit co, input bit ct,
                            input logic [3:0] top, input logic [3:0] rgt,
                            input logic vld, input logic err, input logic tl);
        exp_t e;
        e.cyc = c; e.chk_out = co; e.chk_tail = ct;
        e.top = top; e.rgt = rgt; e.vld = vld; e.err = err; e.tail = tl;
        q.push_back(e);
        nq.push_back(nm);
    endtask

    task automatic push_m(input string nm, input int c);
        push_exp(nm, c, 1'b1, 1'b0, m_top(), m_rgt(), mvalid, merr, 1'b0);
    endtask

    task automatic push_tail(input string nm, input int c, input logic tl);
        push_exp(nm, c, 1'b0, 1'b1, '0, '0, 1'b0, 1'b0, tl);
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        bit    ok;
        forever begin
            @(negedge prog_clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e  = q.pop_front();
                nm = nq.pop_front();
                vectors++;
                if (e.cyc < cyc) begin
                    miscompares++;
                    $display("FAIL %s: check for cycle %0d not taken until cycle %0d", nm, e.cyc, cyc);
                end else begin
                    ok = 1'b1;
                    if (e.chk_out && ({chany_top_out, chanx_right_out, cfg_valid, cfg_err} !==
                                      {e.top, e.rgt, e.vld, e.err})) ok = 1'b0;
                    if (e.chk_tail && (ccff_tail !== e.tail)) ok = 1'b0;
                    if (!ok) begin
                        miscompares++;
                        $display("FAIL %s: cyc=%0d got top=%b rgt=%b vld=%b err=%b tail=%b want top=%b rgt=%b vld=%b err=%b tail=%b",
                                 nm, cyc, chany_top_out, chanx_right_out, cfg_valid, cfg_err, ccff_tail,
                                 e.top, e.rgt, e.vld, e.err, e.tail);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge prog_clk);
        #2;
    endtask

    task automatic shift_bit(input logic b);
        tick();
        ccff_en   = 1'b1;
        ccff_head = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            ccff_en = 1'b0;
        end
    endtask

    function automatic logic [16:0] build(input logic [15:0] sv, input bit bad);
        logic [16:0] f;
        if (PB == 1) f = {sv, (^sv) ^ bad};
        else         f = {1'b0, sv};
        return f;
    endfunction

    task automatic commit_checks(input string nm, input int t, input logic [15:0] sv, input bit bad);
        push_m({nm, " pre"}, t + 1);
        if (bad) begin
            merr = 1'b1;
        end else begin
            msel = sv; mvalid = 1'b1; merr = 1'b0;
        end
        push_m({nm, " post"}, t + 2);
    endtask

    task automatic send_frame(input string nm, input logic [15:0] sv, input bit bad);
        logic [16:0] f;
        f = build(sv, bad);
        for (int k = NB - 1; k >= 0; k--) shift_bit(f[k]);
        commit_checks(nm, cyc, sv, bad);
        idle(2);
    endtask

    initial begin : stim
        logic [16:0]     f;
        logic [2*NB-1:0] s;
        int              t;

        chanx_right_in = 4'b0010;
        tick();
        push_exp("reset state", cyc, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        prog_rst_n = 1'b1;
        idle(2);
        push_exp("idle after reset", cyc, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);

        // All muxes select 1: top i <- top_pins[i%2], right i <- right_pins[i%2].
        tick();
        top_pins   = 2'b01;
        right_pins = 2'b10;
        send_frame("all sel1", 16'h5555, 1'b0);
        push_exp("all sel1 hand", cyc, 1'b1, 1'b0, 4'b0101, 4'b1010, 1'b1, 1'b0, 1'b0);

        // Partial frame with a 5-cycle stall.
        tick();
        chany_top_in   = 4'b1001;
        chanx_right_in = 4'b0110;
        top_pins       = 2'b10;
        right_pins     = 2'b01;
        push_m("new inputs old cfg", cyc);
        f = build(16'h9378, 1'b0);
        for (int k = NB - 1; k >= NB - 10; k--) shift_bit(f[k]);
        for (int h = 0; h < 5; h++) begin
            idle(1);
            push_m("stalled partial frame", cyc);
        end
        for (int k = NB - 11; k >= 0; k--) shift_bit(f[k]);
        commit_checks("resumed frame", cyc, 16'h9378, 1'b0);
        idle(2);

        // Two back-to-back frames; tail shows the stream delayed by one frame length.
        s = {build(16'hA5A5, 1'b0)[NB-1:0], build(16'h5A5A, 1'b0)[NB-1:0]};
        for (int k = 0; k < 2 * NB; k++) begin
            shift_bit(s[2*NB-1-k]);
            t = cyc;
            if (k + 1 >= NB) push_tail("chain tail", t + 1, s[2*NB-1-(k+1-NB)]);
            if (k + 1 == NB)     commit_checks("chain frame1", t, 16'hA5A5, 1'b0);
            if (k + 1 == 2 * NB) commit_checks("chain frame2", t, 16'h5A5A, 1'b0);
        end
        idle(2);

        // Reset in the middle of a frame discards it.
        f = build(16'h1B6C, 1'b0);
        for (int k = NB - 1; k >= NB - 8; k--) shift_bit(f[k]);
        tick();
        prog_rst_n = 1'b0;
        ccff_en    = 1'b0;
        msel = '0; mvalid = 1'b0; merr = 1'b0;
        push_exp("mid-frame reset", cyc, 1'b1, 1'b1, m_top(), m_rgt(), 1'b0, 1'b0, 1'b0);
        tick();
        push_m("held in reset", cyc);
        tick();
        prog_rst_n = 1'b1;
        idle(1);
        send_frame("frame after reset", 16'hE4B1, 1'b0);

`ifdef SB_CFG_PARITY_EN
        send_frame("bad parity", 16'h0FF0, 1'b1);
        send_frame("good parity", 16'h3C3C, 1'b0);
`endif

        idle(3);
        while (q.size() > 0) begin
            miscompares++;
            $display("FAIL %s: check for cycle %0d never taken", nq.pop_front(), q.pop_front().cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
